multicycle_controller: RTL and testbench

Control sequencer for the multicycle RV32I datapath. One shared memory serves both instruction and data, and one ALU serves all arithmetic. The block decodes the latched instruction and steps it through FETCH/DECODE/EXECUTE/MEM/WB states. It drives every mux select and write enable, and stalls on a memory-ready handshake.

---
 rtl/riscv_ctrl_pkg.sv | 58 +++++
 rtl/alu_decoder.sv | 38 +++
 rtl/multicycle_controller.sv | 171 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control sequencer:
// FSM state encodings, opcode constants, ALU control/op codes and the
// mux-select encodings driven onto the datapath.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctl_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RD1   = 2'b10;

  localparam logic [1:0] SRC_B_RD2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode.
//   alu_op      : 00 add, 01 sub, 10 decode from funct fields
//   funct3      : Instr[14:12]
//   op_b5       : Instr[5], distinguishes R-type (1) from I-type (0)
//   funct7b5    : Instr[30]
//   alu_control : ALU operation code
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op_b5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type uses funct7b5 to select sub; addi with Instr[30]
          // set is still an add.
          3'b000:  alu_control = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control sequencer for a multicycle RV32I datapath with a shared
// instruction/data memory and a single ALU.
//   clk, rst_n              : clock, asynchronous active-low reset
//   op, funct3, funct7b5    : fields of the latched instruction
//   zero                    : ALU zero flag (branch resolution)
//   mem_ready               : memory completes the current access this cycle
//   pc_write, ir_write      : PC and IR/OldPC load enables
//   adr_src, mem_write      : memory address select and write strobe
//   result_src, alu_src_a/b : datapath mux selects
//   alu_control, imm_src    : ALU operation and immediate format
//   reg_write               : register file write enable
//   instr_done              : pulse on the last cycle of every instruction
//   illegal_instr           : pulse in DECODE for an unsupported opcode
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal_instr
);

  state_t     state, next_state;
  alu_op_t    alu_op;
  logic       pc_update, branch;
  logic       ir_write_c, mem_write_c, reg_write_c, done_c, illegal_c;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its input from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET_STATE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = S_FETCH;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RD2;
    alu_op      = ALUOP_ADD;
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    done_c      = 1'b0;
    illegal_c   = 1'b0;

    case (state)
      S_FETCH: begin
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALURESULT;
        ir_write_c = mem_ready;
        pc_update  = mem_ready;
        next_state = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          default: begin
            illegal_c  = 1'b1;
            done_c     = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRC_A_RD1;
        alu_src_b  = SRC_B_IMM;
        next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
      end
      S_MEMWRITE: begin
        // The strobe stays up through the cycle the memory accepts it.
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        done_c      = mem_ready;
        next_state  = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a  = SRC_A_RD1;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRC_A_RD1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = SRC_A_RD1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        done_c    = 1'b1;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        pc_update  = 1'b1;
        next_state = S_ALUWB;
      end
      default: next_state = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_b5       (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

  // Enables are gated by rst_n so nothing is written while reset is held,
  // even though FETCH would otherwise follow mem_ready.
  assign pc_write      = rst_n & (pc_update | (branch & zero));
  assign ir_write      = rst_n & ir_write_c;
  assign mem_write     = rst_n & mem_write_c;
  assign reg_write     = rst_n & reg_write_c;
  assign instr_done    = rst_n & done_c;
  assign illegal_instr = rst_n & illegal_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each vector holds the
// inputs for one cycle and the expected outputs as an 18-bit field in the
// order pc_write,adr_src,mem_write,ir_write,result_src,alu_src_a,alu_src_b,
// alu_control,imm_src,reg_write,instr_done,illegal_instr.
module tb_multicycle_controller;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic       pc_write, adr_src, mem_write, ir_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic       reg_write, instr_done, illegal_instr;
  } out_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  out_t act;

  int checks = 0, errors = 0;
  vec_t vecs[$];
  out_t exp_q[$];
  string name_q[$];
  logic watch_rw = 1'b0, rw_seen = 1'b0;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .reg_write(reg_write), .instr_done(instr_done),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  assign act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, alu_control, imm_src, reg_write, instr_done, illegal_instr};

  always @(reg_write) if (watch_rw && reg_write) rw_seen = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0b want=%0b", name, got, want);
    end
  endtask

  function automatic vec_t row(input string n, input logic [6:0] o, input logic [2:0] f3,
                               input logic f7, input logic z, input logic rdy,
                               input logic [17:0] e);
    vec_t v;
    v.name = n; v.op = o; v.funct3 = f3; v.funct7b5 = f7; v.zero = z;
    v.mem_ready = rdy; v.exp = e;
    return v;
  endfunction

  // Drive one cycle of stimulus just after a rising edge, queue the
  // expectation, then pop and compare at the falling edge.
  task automatic apply(input vec_t v);
    op = v.op; funct3 = v.funct3; funct7b5 = v.funct7b5;
    zero = v.zero; mem_ready = v.mem_ready;
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
    @(negedge clk);
    check(name_q.pop_front(), 32'(act), 32'(exp_q.pop_front()));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Straight-line instruction stream, mem_ready mostly high.
    vecs.push_back(row("r_fetch",   RT, 3'b000, 1, 0, 1, 18'b1_0_0_1_10_00_10_000_00_0_0_0));
    vecs.push_back(row("r_decode",  RT, 3'b000, 1, 0, 1, 18'b0_0_0_0_00_01_01_000_00_0_0_0));
    vecs.push_back(row("r_execr",   RT, 3'b000, 1, 0, 1, 18'b0_0_0_0_00_10_00_001_00_0_0_0));
    vecs.push_back(row("r_aluwb",   RT, 3'b000, 1, 0, 1, 18'b0_0_0_0_00_00_00_000_00_1_1_0));
    vecs.push_back(row("stall_f",   RT, 3'b010, 0, 0, 0, 18'b0_0_0_0_10_00_10_000_00_0_0_0));
    vecs.push_back(row("slt_fetch", RT, 3'b010, 0, 0, 1, 18'b1_0_0_1_10_00_10_000_00_0_0_0));
    vecs.push_back(row("slt_dec",   RT, 3'b010, 0, 0, 1, 18'b0_0_0_0_00_01_01_000_00_0_0_0));
    vecs.push_back(row("slt_exec",  RT, 3'b010, 0, 0, 1, 18'b0_0_0_0_00_10_00_101_00_0_0_0));
    vecs.push_back(row("slt_wb",    RT, 3'b010, 0, 0, 1, 18'b0_0_0_0_00_00_00_000_00_1_1_0));
    vecs.push_back(row("addi_f",    IT, 3'b000, 1, 0, 1, 18'b1_0_0_1_10_00_10_000_00_0_0_0));
    vecs.push_back(row("addi_d",    IT, 3'b000, 1, 0, 1, 18'b0_0_0_0_00_01_01_000_00_0_0_0));
    vecs.push_back(row("addi_exec", IT, 3'b000, 1, 0, 1, 18'b0_0_0_0_00_10_01_000_00_0_0_0));
    vecs.push_back(row("addi_wb",   IT, 3'b000, 1, 0, 1, 18'b0_0_0_0_00_00_00_000_00_1_1_0));
    vecs.push_back(row("andi_f",    IT, 3'b111, 0, 0, 1, 18'b1_0_0_1_10_00_10_000_00_0_0_0));
    vecs.push_back(row("andi_d",    IT, 3'b111, 0, 0, 1, 18'b0_0_0_0_00_01_01_000_00_0_0_0));
    vecs.push_back(row("andi_exec", IT, 3'b111, 0, 0, 1, 18'b0_0_0_0_00_10_01_010_00_0_0_0));
    vecs.push_back(row("andi_wb",   IT, 3'b111, 0, 0, 1, 18'b0_0_0_0_00_00_00_000_00_1_1_0));
    vecs.push_back(row("beq1_f",    BQ, 3'b000, 0, 1, 1, 18'b1_0_0_1_10_00_10_000_10_0_0_0));
    vecs.push_back(row("beq1_d",    BQ, 3'b000, 0, 1, 1, 18'b0_0_0_0_00_01_01_000_10_0_0_0));
    vecs.push_back(row("beq1_taken",BQ, 3'b000, 0, 1, 1, 18'b1_0_0_0_00_10_00_001_10_0_1_0));
    vecs.push_back(row("beq0_f",    BQ, 3'b000, 0, 0, 1, 18'b1_0_0_1_10_00_10_000_10_0_0_0));
    vecs.push_back(row("beq0_d",    BQ, 3'b000, 0, 0, 1, 18'b0_0_0_0_00_01_01_000_10_0_0_0));
    vecs.push_back(row("beq0_not",  BQ, 3'b000, 0, 0, 1, 18'b0_0_0_0_00_10_00_001_10_0_1_0));
    vecs.push_back(row("sw_f",      SW, 3'b010, 0, 0, 1, 18'b1_0_0_1_10_00_10_000_01_0_0_0));
    vecs.push_back(row("sw_d",      SW, 3'b010, 0, 0, 1, 18'b0_0_0_0_00_01_01_000_01_0_0_0));
    vecs.push_back(row("sw_adr",    SW, 3'b010, 0, 0, 1, 18'b0_0_0_0_00_10_01_000_01_0_0_0));
    vecs.push_back(row("sw_wait",   SW, 3'b010, 0, 0, 0, 18'b0_1_1_0_00_00_00_000_01_0_0_0));
    vecs.push_back(row("sw_write",  SW, 3'b010, 0, 0, 1, 18'b0_1_1_0_00_00_00_000_01_0_1_0));
    vecs.push_back(row("jal_f",     JL, 3'b000, 0, 0, 1, 18'b1_0_0_1_10_00_10_000_11_0_0_0));
    vecs.push_back(row("jal_d",     JL, 3'b000, 0, 0, 1, 18'b0_0_0_0_00_01_01_000_11_0_0_0));
    vecs.push_back(row("jal_jal",   JL, 3'b000, 0, 0, 1, 18'b1_0_0_0_00_01_10_000_11_0_0_0));
    vecs.push_back(row("jal_wb",    JL, 3'b000, 0, 0, 1, 18'b0_0_0_0_00_00_00_000_11_1_1_0));
    vecs.push_back(row("ill_f",     BAD, 3'b000, 0, 0, 1, 18'b1_0_0_1_10_00_10_000_00_0_0_0));
    vecs.push_back(row("ill_d",     BAD, 3'b000, 0, 0, 1, 18'b0_0_0_0_00_01_01_000_00_0_1_1));
    vecs.push_back(row("ill_back_f",RT, 3'b000, 0, 0, 0, 18'b0_0_0_0_10_00_10_000_00_0_0_0));

    // Reset: FETCH selects visible, every enable gated low despite mem_ready.
    mem_ready = 1'b1;
    #12;
    check("reset_outputs", 32'(act), 32'(18'b0_0_0_0_10_00_10_000_00_0_0_0));
    mem_ready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[k]) apply(vecs[k]);

    // lw with three wait cycles in MEMREAD: eight cycles in total.
    apply(row("lw_f",    LW, 3'b010, 0, 0, 1, 18'b1_0_0_1_10_00_10_000_00_0_0_0));
    apply(row("lw_d",    LW, 3'b010, 0, 0, 1, 18'b0_0_0_0_00_01_01_000_00_0_0_0));
    apply(row("lw_adr",  LW, 3'b010, 0, 0, 1, 18'b0_0_0_0_00_10_01_000_00_0_0_0));
    for (int w = 0; w < 3; w++)
      apply(row("lw_wait", LW, 3'b010, 0, 0, 0, 18'b0_1_0_0_00_00_00_000_00_0_0_0));
    apply(row("lw_read", LW, 3'b010, 0, 0, 1, 18'b0_1_0_0_00_00_00_000_00_0_0_0));
    apply(row("lw_wb",   LW, 3'b010, 0, 0, 1, 18'b0_0_0_0_01_00_00_000_00_1_1_0));

    // Reset asserted mid-MEMWRITE abandons the store.
    watch_rw = 1'b1;
    apply(row("rsw_f",   SW, 3'b000, 0, 0, 1, 18'b1_0_0_1_10_00_10_000_01_0_0_0));
    apply(row("rsw_d",   SW, 3'b000, 0, 0, 1, 18'b0_0_0_0_00_01_01_000_01_0_0_0));
    apply(row("rsw_adr", SW, 3'b000, 0, 0, 1, 18'b0_0_0_0_00_10_01_000_01_0_0_0));
    mem_ready = 1'b0;
    @(negedge clk);
    check("rsw_mem_write_before", 32'(mem_write), 32'(1));
    #1 rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rsw_mem_write_in_reset", 32'(mem_write), 32'(0));
    check("rsw_outputs_in_reset", 32'(act), 32'(18'b0_0_0_0_10_00_10_000_01_0_0_0));
    mem_ready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(row("rsw_refetch", RT, 3'b000, 0, 0, 1, 18'b1_0_0_1_10_00_10_000_00_0_0_0));
    watch_rw = 1'b0;
    check("rsw_no_reg_write", 32'(rw_seen), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
